// File: rtl/bidir_shift_tx.sv
// Parallel-to-serial transmitter feeding a bidirectional shift register's d0/d1/sel inputs.
// Latency: first bit on the line the cycle after load; done one cycle after the last serial bit.
// Backpressure: load_ready is high only in IDLE; load_valid while busy is ignored.
// Optional feature: define BIDIR_SHIFT_TX_PARITY_EN to append an even-parity bit to every frame.
module bidir_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [1:0]       sel,
  output logic             d0,
  output logic             d1,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef BIDIR_SHIFT_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] word, word_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             dir_q, dir_nx;
  logic [1:0]       sel_nx;
  logic             d0_nx, d1_nx, busy_nx, done_nx;
`ifdef BIDIR_SHIFT_TX_PARITY_EN
  logic             par, par_nx;
`endif

  assign load_ready = (state == IDLE);

  // Next-state and next-output decode. The bit driven on the line is the one
  // leaving the buffer, so the buffer always holds the bits not yet sent and
  // cnt counts the bits already put on the line after the first one.
  always_comb begin
    state_nx = state;
    word_nx  = word;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    sel_nx   = 2'b00;
    d0_nx    = 1'b0;
    d1_nx    = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
`ifdef BIDIR_SHIFT_TX_PARITY_EN
    par_nx   = par;
`endif
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          state_nx = SHIFT;
          dir_nx   = dir;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
`ifdef BIDIR_SHIFT_TX_PARITY_EN
          par_nx   = ^din;
`endif
          if (!dir) begin
            sel_nx  = 2'b10;
            d0_nx   = din[WIDTH-1];
            word_nx = din << 1;
          end else begin
            sel_nx  = 2'b01;
            d1_nx   = din[0];
            word_nx = din >> 1;
          end
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef BIDIR_SHIFT_TX_PARITY_EN
          state_nx = PARITY;
          busy_nx  = 1'b1;
          sel_nx   = dir_q ? 2'b01 : 2'b10;
          d0_nx    = !dir_q && par;
          d1_nx    = dir_q && par;
`else
          state_nx = IDLE;
          done_nx  = 1'b1;
`endif
        end else begin
          busy_nx = 1'b1;
          cnt_nx  = cnt + CW'(1);
          if (!dir_q) begin
            sel_nx  = 2'b10;
            d0_nx   = word[WIDTH-1];
            word_nx = word << 1;
          end else begin
            sel_nx  = 2'b01;
            d1_nx   = word[0];
            word_nx = word >> 1;
          end
        end
      end
`ifdef BIDIR_SHIFT_TX_PARITY_EN
      PARITY: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // State, buffer and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
      sel   <= 2'b00;
      d0    <= 1'b0;
      d1    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BIDIR_SHIFT_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      word  <= word_nx;
      cnt   <= cnt_nx;
      dir_q <= dir_nx;
      sel   <= sel_nx;
      d0    <= d0_nx;
      d1    <= d1_nx;
      busy  <= busy_nx;
      done  <= done_nx;
`ifdef BIDIR_SHIFT_TX_PARITY_EN
      par   <= par_nx;
`endif
    end
  end

endmodule
